traffic_light: RTL and testbench
================================

Name: traffic_light

Overview:
Two-road intersection controller (main road and side road) driving one 3-bit signal head per road. A Moore FSM cycles green, yellow, all-red and the opposite green on fixed cycle-count timers. Special-vehicle (priority) request inputs cut the conflicting green short. It sits between the pushbutton/detector inputs and the lamp drivers.

Parameters:
MAIN_GREEN_CYCLES, 120, clocks main road stays green (>=1)
SIDE_GREEN_CYCLES, 60, clocks side road stays green (>=1)
YELLOW_CYCLES, 5, clocks of each yellow phase (>=1)
ALL_RED_CYCLES, 2, clocks of each all-red clearance (>=1; used only with TLC_ALL_RED_EN)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  reset, asynchronous, active-high
Main_Special  in  1  priority request for main road green; may be a 1-2 cycle pulse
Side_Special  in  1  priority request for side road green; may be a 1-2 cycle pulse
Main_light  out  3  main road lamp {red,yellow,green}, one-hot
Side_light  out  3  side road lamp {red,yellow,green}, one-hot

Behaviour:
- One clock (Clk); reset is asynchronous and active-high (Rst).
- Lamp encoding: RED=3'b100, YELLOW=3'b010, GREEN=3'b001. Outputs decoded only from the state register (Moore). No combinational path from inputs to outputs.
- States: MG (main GREEN, side RED), MY (main YELLOW, side RED), AR1 (both RED), SG (main RED, side GREEN), SY (main RED, side YELLOW), AR2 (both RED).
- Normal sequence: MG -> MY -> AR1 -> SG -> SY -> AR2 -> MG.
- Phase counter cleared on every state entry. A state of length N is left at the edge where counter==N-1, so it lasts exactly N clocks.
- Reset: state=MG, counter=0, both pending flags=0. Outputs Main_light=3'b001, Side_light=3'b100 while Rst is high and in the first cycle after release.
- Effective request = input OR its pending flag. It is evaluated at every rising edge.
- Side request in MG: go to MY at that edge, ignoring the remaining green time.
- Main request in SG: go to SY at that edge, ignoring the remaining green time.
- Request for a road that is already green: the counter reloads to 0 (green restarts for its full duration) and the flag clears.
- Requests arriving during yellow or all-red: latched in the pending flag. They never shorten yellow or all-red.
- A pending flag clears on entry to its road's green.
- Both requests effective in the same cycle: main road has priority. The side request stays pending and is served after main green runs its full MAIN_GREEN_CYCLES (it does not pre-empt the green just granted).
- Exactly one road may show non-RED at any time. GREEN to GREEN always passes through YELLOW.
- Rst asserted mid-phase: immediately return to the reset state. Pending requests are discarded.
- Counter width: $clog2 of the largest parameter +1.

Optional Feature:
Macro TLC_ALL_RED_EN.
- Defined: AR1/AR2 exist and last ALL_RED_CYCLES each, giving a default full cycle of 194 clocks.
- Undefined: AR1/AR2 are removed, MY goes directly to SG and SY goes directly to MG, giving a default full cycle of 190 clocks. Request and priority rules are otherwise unchanged.

Test Plan:
- Reset held then released, no requests (TLC_ALL_RED_EN defined):
  - Main=001/Side=100 for 120 clocks, then Main=010 for 5.
  - Then both 100 for 2, then Side=001 for 60, Side=010 for 5, both 100 for 2.
  - Back to Main=001 at clock 194.
- Side_Special pulsed 3 clocks, starting 5 clocks after reset release (in MG) -> Main=010 from that edge for 5 clocks, 2 all-red, then Side=001 for 60 clocks. After serving it, the normal sequence resumes.
- Main_Special 1-clock pulse during SG (clock 20 of SG) -> SY immediately for 5 clocks, all-red for 2, then MG for 120 clocks.
- Main_Special pulse during SY -> yellow still lasts 5 clocks. Request stays pending, then MG is entered with a full 120 clocks and the flag clears.
- Both requests on the same edge during AR2 -> MG is entered and runs its full 120 clocks (main priority). The side request stays pending; the sequence then goes MY, AR1, SG. Check at every clock that no GREEN/YELLOW overlap occurs.
- Rst asserted mid-SG with a side request pending -> outputs Main=001/Side=100 asynchronously. After release, MG lasts a full 120 clocks (pending request discarded).

Source files
------------

// File: rtl/traffic_light.sv
// Two-road intersection controller: Moore FSM with fixed phase timers and priority requests.
// The all-red clearance phases are included only when TLC_ALL_RED_EN is defined.
module traffic_light #(
    parameter int MAIN_GREEN_CYCLES = 120,
    parameter int SIDE_GREEN_CYCLES = 60,
    parameter int YELLOW_CYCLES     = 5,
    parameter int ALL_RED_CYCLES    = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Main_Special,
    input  logic       Side_Special,
    output logic [2:0] Main_light,
    output logic [2:0] Side_light
);

    localparam int MAX_GREEN = (MAIN_GREEN_CYCLES > SIDE_GREEN_CYCLES) ? MAIN_GREEN_CYCLES : SIDE_GREEN_CYCLES;
    localparam int MAX_CLEAR = (YELLOW_CYCLES > ALL_RED_CYCLES) ? YELLOW_CYCLES : ALL_RED_CYCLES;
    localparam int MAX_LEN   = (MAX_GREEN > MAX_CLEAR) ? MAX_GREEN : MAX_CLEAR;
    localparam int CW        = $clog2(MAX_LEN) + 1;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          main_pend_q, main_pend_d;
    logic          side_pend_q, side_pend_d;
    // Set when a side request lost to main priority: it must wait out the full main green.
    logic          side_hold_q, side_hold_d;

    logic main_req;
    logic side_req;
    logic mg_done;
    logic sg_done;
    logic y_done;
    logic ar_done;

    assign main_req = Main_Special | main_pend_q;
    assign side_req = Side_Special | side_pend_q;
    assign mg_done  = (cnt_q == CW'(MAIN_GREEN_CYCLES - 1));
    assign sg_done  = (cnt_q == CW'(SIDE_GREEN_CYCLES - 1));
    assign y_done   = (cnt_q == CW'(YELLOW_CYCLES - 1));
    assign ar_done  = (cnt_q == CW'(ALL_RED_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        main_pend_d = main_pend_q;
        side_pend_d = side_pend_q;
        side_hold_d = side_hold_q;

        case (state_q)
            MG: begin
                if (main_req) begin
                    cnt_d       = '0;
                    main_pend_d = 1'b0;
                    if (side_req) begin
                        side_pend_d = 1'b1;
                        side_hold_d = 1'b1;
                    end
                end else if (Side_Special || (side_pend_q && !side_hold_q)) begin
                    state_d     = MY;
                    cnt_d       = '0;
                    side_pend_d = 1'b1;
                end else if (mg_done) begin
                    state_d = MY;
                    cnt_d   = '0;
                end
            end

            SG: begin
                if (main_req) begin
                    state_d     = SY;
                    cnt_d       = '0;
                    main_pend_d = 1'b1;
                    if (side_req) begin
                        side_pend_d = 1'b1;
                        side_hold_d = 1'b1;
                    end
                end else if (side_req) begin
                    cnt_d       = '0;
                    side_pend_d = 1'b0;
                    side_hold_d = 1'b0;
                end else if (sg_done) begin
                    state_d = SY;
                    cnt_d   = '0;
                end
            end

            // Clearance phases only latch requests; their lengths are never shortened.
            MY: begin
                main_pend_d = main_req;
                side_pend_d = side_req;
                if (y_done) begin
                    cnt_d = '0;
`ifdef TLC_ALL_RED_EN
                    state_d = AR1;
`else
                    state_d     = SG;
                    side_pend_d = 1'b0;
                    side_hold_d = 1'b0;
`endif
                end
            end

            SY: begin
                main_pend_d = main_req;
                side_pend_d = side_req;
                if (y_done) begin
                    cnt_d = '0;
`ifdef TLC_ALL_RED_EN
                    state_d = AR2;
`else
                    state_d     = MG;
                    main_pend_d = 1'b0;
                    side_hold_d = side_req & (main_req | side_hold_q);
`endif
                end
            end

`ifdef TLC_ALL_RED_EN
            AR1: begin
                main_pend_d = main_req;
                side_pend_d = side_req;
                if (ar_done) begin
                    state_d     = SG;
                    cnt_d       = '0;
                    side_pend_d = 1'b0;
                    side_hold_d = 1'b0;
                end
            end

            AR2: begin
                main_pend_d = main_req;
                side_pend_d = side_req;
                if (ar_done) begin
                    state_d     = MG;
                    cnt_d       = '0;
                    main_pend_d = 1'b0;
                    side_hold_d = side_req & (main_req | side_hold_q);
                end
            end
`endif

            default: begin
                state_d     = MG;
                cnt_d       = '0;
                main_pend_d = 1'b0;
                side_pend_d = 1'b0;
                side_hold_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= MG;
            cnt_q       <= '0;
            main_pend_q <= 1'b0;
            side_pend_q <= 1'b0;
            side_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            main_pend_q <= main_pend_d;
            side_pend_q <= side_pend_d;
            side_hold_q <= side_hold_d;
        end
    end

    always_comb begin
        Main_light = LAMP_RED;
        Side_light = LAMP_RED;
        case (state_q)
            MG:      Main_light = LAMP_GREEN;
            MY:      Main_light = LAMP_YELLOW;
            SG:      Side_light = LAMP_GREEN;
            SY:      Side_light = LAMP_YELLOW;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light: phase lengths, priority pre-emption, pending requests and reset.
module tb_traffic_light;

`ifdef TLC_ALL_RED_EN
    localparam int AR = 2;
`else
    localparam int AR = 0;
`endif

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Main_Special;
    logic       Side_Special;
    logic [2:0] Main_light;
    logic [2:0] Side_light;

    int total = 0;
    int bad   = 0;

    traffic_light dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Main_Special (Main_Special),
        .Side_Special (Side_Special),
        .Main_light   (Main_light),
        .Side_light   (Side_light)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b expected=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Checks n consecutive samples of one lamp pair, plus the one-road-non-red rule.
    task automatic phase(input string tag, input logic [2:0] m, input logic [2:0] s, input int n);
        int nonred;
        for (int i = 0; i < n; i++) begin
            check(tag, {Main_light, Side_light}, {m, s});
            nonred = int'(Main_light != R) + int'(Side_light != R);
            check("excl", {5'b0, nonred <= 1}, 6'd1);
            tick();
        end
        $display("phase %s main=%b side=%b len=%0d t=%0t", tag, m, s, n, $time);
    endtask

    task automatic do_reset(input string tag);
        Rst          = 1'b1;
        Main_Special = 1'b0;
        Side_Special = 1'b0;
        tick();
        tick();
        check(tag, {Main_light, Side_light}, {G, R});
        Rst = 1'b0;
    endtask

    task automatic run_to_sg();
        phase("mg", G, R, 120);
        phase("my", Y, R, 5);
        phase("ar1", R, R, AR);
    endtask

    initial begin
        Rst          = 1'b1;
        Main_Special = 1'b0;
        Side_Special = 1'b0;

        // Free-running cycle
        do_reset("rst1");
        run_to_sg();
        phase("sg", R, G, 60);
        phase("sy", R, Y, 5);
        phase("ar2", R, R, AR);
        phase("mg_wrap", G, R, 1);

        // Side request pre-empts main green
        do_reset("rst2");
        phase("mg_pre", G, R, 5);
        Side_Special = 1'b1;
        phase("mg_req", G, R, 1);
        phase("my_cut", Y, R, 2);
        Side_Special = 1'b0;
        phase("my_cut", Y, R, 3);
        phase("ar1_cut", R, R, AR);
        phase("sg_srv", R, G, 60);
        phase("sy_srv", R, Y, 5);
        phase("ar2_srv", R, R, AR);
        phase("mg_resume", G, R, 120);
        phase("my_resume", Y, R, 1);

        // Main request pre-empts side green at clock 20
        do_reset("rst3");
        run_to_sg();
        phase("sg_pre", R, G, 20);
        Main_Special = 1'b1;
        phase("sg_req", R, G, 1);
        Main_Special = 1'b0;
        phase("sy_cut", R, Y, 5);
        phase("ar2_cut", R, R, AR);
        phase("mg_srv", G, R, 120);
        phase("my_srv", Y, R, 1);

        // Main request during yellow is held, not used to shorten it
        do_reset("rst4");
        run_to_sg();
        phase("sg", R, G, 60);
        phase("sy_a", R, Y, 2);
        Main_Special = 1'b1;
        phase("sy_req", R, Y, 1);
        Main_Special = 1'b0;
        phase("sy_b", R, Y, 2);
        phase("ar2_hold", R, R, AR);
        phase("mg_full", G, R, 120);
        phase("my_after", Y, R, 1);

        // Both requests together during clearance: main wins, side waits for full main green
        do_reset("rst5");
        run_to_sg();
        phase("sg", R, G, 60);
`ifdef TLC_ALL_RED_EN
        phase("sy", R, Y, 5);
        Main_Special = 1'b1;
        Side_Special = 1'b1;
        phase("ar2_req", R, R, 1);
        Main_Special = 1'b0;
        Side_Special = 1'b0;
        phase("ar2_end", R, R, 1);
`else
        phase("sy_a", R, Y, 2);
        Main_Special = 1'b1;
        Side_Special = 1'b1;
        phase("sy_req", R, Y, 1);
        Main_Special = 1'b0;
        Side_Special = 1'b0;
        phase("sy_b", R, Y, 2);
`endif
        phase("mg_both", G, R, 120);
        phase("my_both", Y, R, 5);
        phase("ar1_both", R, R, AR);
        phase("sg_both", R, G, 60);
        phase("sy_both", R, Y, 1);

        // Asynchronous reset mid side green with a side request present
        do_reset("rst6");
        run_to_sg();
        phase("sg_pre", R, G, 30);
        Side_Special = 1'b1;
        #2;
        Rst = 1'b1;
        #1;
        check("async_rst", {Main_light, Side_light}, {G, R});
        tick();
        Side_Special = 1'b0;
        check("rst_held", {Main_light, Side_light}, {G, R});
        tick();
        Rst = 1'b0;
        phase("mg_post_rst", G, R, 120);
        phase("my_post_rst", Y, R, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
